fifo_ptr_mc: RTL and testbench
==============================

// Module: fifo_ptr_mc
// PURPOSE
// - Single-clock pointer/flag manager for 2**CH_log independent logical FIFOs sharing one
//   external simple-dual-port RAM of 2**(CH_log+N_log) words; channel c owns region {c, ptr}.
// - Sits between multi-channel producers/consumers and the shared buffer RAM.
// - Adds to the async pointer block: channel count, per-channel word counters, almost-full
//   thresholds and optional sticky error flags.
// PARAMETERS
// - N_log        8   per-channel pointer bits; depth 2**N_log; counts are N_log+1 bits
// - CH_log       2   channel index bits; N_CH = 2**CH_log
// - RD_PTR_UNBUF 1   1: o_rd_addr_nxt uses next read ptr (sync RAM); 0: current ptr
// - AFULL_THR    192 almost-full threshold in words, 1..2**N_log
// PORTS
// - clk             in   1              clock
// - rst             in   1              synchronous reset, active high
// - i_wr_advance    in   1              write request for channel i_wr_ch
// - i_wr_ch         in   CH_log         write channel select
// - o_wr_addr       out  CH_log+N_log   RAM write address {i_wr_ch, wr_ptr_q[i_wr_ch]}
// - o_wr_full       out  N_CH           per-channel full, registered
// - o_wr_afull      out  N_CH           per-channel almost full (count >= AFULL_THR), registered
// - i_rd_advance    in   1              read/pop request for channel i_rd_ch
// - i_rd_ch         in   CH_log         read channel select
// - o_rd_addr_nxt   out  CH_log+N_log   RAM read address (see RD_PTR_UNBUF)
// - o_rd_empty      out  N_CH           per-channel empty, registered
// - o_rd_words      out  N_log+1        count_q[i_rd_ch], combinational from registered state
// - o_err           out  2              sticky errors {rd_underflow, wr_overflow}
// BEHAVIOUR
// - Reset (sync, high): all wr_ptr/rd_ptr/count = 0; o_rd_empty = all 1; o_wr_full = 0;
//   o_wr_afull = 0; o_err = 0. rst mid-operation discards all contents; the cycle after is
//   identical to post-reset.
// - wr_acc = i_wr_advance & ~full_q[i_wr_ch]; rd_acc = i_rd_advance & ~empty_q[i_rd_ch].
// - Accepted write: RAM written at o_wr_addr on the same edge; wr_ptr[i_wr_ch] += 1, wraps
//   mod 2**N_log.
// - Accepted read: rd_ptr[i_rd_ch] += 1, wraps mod 2**N_log.
// - count[c] next = count[c] + (wr_acc & wr_ch==c) - (rd_acc & rd_ch==c); never wraps.
// - Flags are registered from next count: full = (count == 2**N_log); empty = (count == 0);
//   afull = (count >= AFULL_THR). All channels update every cycle.
// - Latency: write at edge t -> empty clears at t+1; data readable from t+1. Read that empties
//   a channel at edge t -> empty asserts at t+1.
// - No fall-through: read on an empty channel is rejected even with a same-cycle write to it.
// - Write on a full channel is rejected even with a same-cycle read of it.
// - Same channel, write and read both accepted: count unchanged, both pointers advance.
// - Different channels, same cycle: fully independent updates.
// - o_rd_addr_nxt = {i_rd_ch, rd_acc ? rd_ptr_q+1 : rd_ptr_q} when RD_PTR_UNBUF=1, so RAM
//   output at t+1 is the new head of i_rd_ch. When 0: {i_rd_ch, rd_ptr_q[i_rd_ch]}.
// - Rejected requests change no state other than o_err.
// CONFIGURATION
// - Macro FIFO_PTR_MC_ERR_EN defined:
//   - o_err[0] sets on i_wr_advance & full_q[i_wr_ch].
//   - o_err[1] sets on i_rd_advance & empty_q[i_rd_ch].
//   - Both bits are sticky and cleared only by rst; they assert the cycle after the offending request.
// - Not defined: o_err tied to 2'b00 and no error registers are built.
// TESTING
// - Post-reset, no requests -> o_rd_empty=all 1, o_wr_full=0, o_rd_words=0, o_err=0.
// - 256 writes to ch1 (N_log=8) -> o_wr_afull[1]=1 after the 192nd write, o_wr_full[1]=1
//   after the 256th. A 257th write is rejected: o_wr_addr unchanged, and o_err[0]=1 if ERR_EN.
// - Fill ch2 with 4 words, then read and write ch2 together for 10 cycles -> o_rd_words stays 4,
//   addresses wrap 255->0 when preloaded near the end of the region.
// - Empty ch0, write and read ch0 in the same cycle -> read rejected, count=1 at t+1.
//   With ERR_EN: o_err[1]=1.
// - Interleaved writes to ch0 and reads of ch3 every cycle -> both channels update
//   independently, with no cross-channel pointer or flag corruption.
// - Assert rst with ch1 holding 50 words and a read in flight -> at t+1 all channels are
//   empty, counts are 0 and o_err=0.

Source files
------------

// File: rtl/fifo_ptr_mc.sv
// Pointer, word-count and flag manager for 2**CH_log logical FIFOs sharing one SDP RAM.
// Optional sticky error flags are built when FIFO_PTR_MC_ERR_EN is defined.
module fifo_ptr_mc #(
  parameter int N_log        = 8,
  parameter int CH_log       = 2,
  parameter int RD_PTR_UNBUF = 1,
  parameter int AFULL_THR    = 192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_advance,
  input  logic [CH_log-1:0]       i_wr_ch,
  output logic [CH_log+N_log-1:0] o_wr_addr,
  output logic [(1<<CH_log)-1:0]  o_wr_full,
  output logic [(1<<CH_log)-1:0]  o_wr_afull,
  input  logic                    i_rd_advance,
  input  logic [CH_log-1:0]       i_rd_ch,
  output logic [CH_log+N_log-1:0] o_rd_addr_nxt,
  output logic [(1<<CH_log)-1:0]  o_rd_empty,
  output logic [N_log:0]          o_rd_words,
  output logic [1:0]              o_err
);

  localparam int             N_CH      = 1 << CH_log;
  localparam logic [N_log:0] DEPTH_CNT = (N_log+1)'(1 << N_log);
  localparam logic [N_log:0] AFULL_CNT = (N_log+1)'(AFULL_THR);
  localparam logic [N_log:0] CNT_ONE   = (N_log+1)'(1);

  logic [N_log-1:0] wr_ptr_p1 [N_CH];
  logic [N_log-1:0] rd_ptr_p1 [N_CH];
  logic [N_log:0]   count_p1  [N_CH];
  logic [N_log:0]   count_p0  [N_CH];
  logic [N_CH-1:0]  full_p1;
  logic [N_CH-1:0]  afull_p1;
  logic [N_CH-1:0]  empty_p1;
  logic             wr_acc;
  logic             rd_acc;
  logic [N_log-1:0] rd_ptr_sel;

  function automatic logic [N_log-1:0] ptr_inc(input logic [N_log-1:0] p);
    return p + N_log'(1);
  endfunction

  assign wr_acc     = i_wr_advance & ~full_p1[i_wr_ch];
  assign rd_acc     = i_rd_advance & ~empty_p1[i_rd_ch];
  assign rd_ptr_sel = rd_ptr_p1[i_rd_ch];

  // Stage p0: next count for every channel; acceptance already excludes full/empty
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      count_p0[c] = count_p1[c];
      if (wr_acc && (i_wr_ch == CH_log'(c))) count_p0[c] = count_p0[c] + CNT_ONE;
      if (rd_acc && (i_rd_ch == CH_log'(c))) count_p0[c] = count_p0[c] - CNT_ONE;
    end
  end

  // Stage p1: pointers, counts and flags registered from the p0 counts
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr_p1[c] <= '0;
        rd_ptr_p1[c] <= '0;
        count_p1[c]  <= '0;
      end
      full_p1  <= '0;
      afull_p1 <= '0;
      empty_p1 <= '1;
    end else begin
      if (wr_acc) wr_ptr_p1[i_wr_ch] <= ptr_inc(wr_ptr_p1[i_wr_ch]);
      if (rd_acc) rd_ptr_p1[i_rd_ch] <= ptr_inc(rd_ptr_p1[i_rd_ch]);
      for (int c = 0; c < N_CH; c++) begin
        count_p1[c] <= count_p0[c];
        full_p1[c]  <= (count_p0[c] == DEPTH_CNT);
        afull_p1[c] <= (count_p0[c] >= AFULL_CNT);
        empty_p1[c] <= (count_p0[c] == '0);
      end
    end
  end

  assign o_wr_addr  = {i_wr_ch, wr_ptr_p1[i_wr_ch]};
  assign o_wr_full  = full_p1;
  assign o_wr_afull = afull_p1;
  assign o_rd_empty = empty_p1;
  assign o_rd_words = count_p1[i_rd_ch];

  // A synchronous-read RAM needs the post-pop head address presented this cycle
  generate
    if (RD_PTR_UNBUF != 0) begin : g_rd_unbuf
      assign o_rd_addr_nxt = {i_rd_ch, rd_acc ? ptr_inc(rd_ptr_sel) : rd_ptr_sel};
    end else begin : g_rd_buf
      assign o_rd_addr_nxt = {i_rd_ch, rd_ptr_sel};
    end
  endgenerate

`ifdef FIFO_PTR_MC_ERR_EN
  logic [1:0] err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_p1 <= '0;
    end else begin
      if (i_wr_advance && full_p1[i_wr_ch])  err_p1[0] <= 1'b1;
      if (i_rd_advance && empty_p1[i_rd_ch]) err_p1[1] <= 1'b1;
    end
  end

  assign o_err = err_p1;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_ptr_mc.sv
// Directed self-checking bench for fifo_ptr_mc (default parameters: 4 channels, depth 256).
module tb_fifo_ptr_mc;

`ifdef FIFO_PTR_MC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i_wr_advance;
  logic [1:0] i_wr_ch;
  logic [9:0] o_wr_addr;
  logic [3:0] o_wr_full;
  logic [3:0] o_wr_afull;
  logic       i_rd_advance;
  logic [1:0] i_rd_ch;
  logic [9:0] o_rd_addr_nxt;
  logic [3:0] o_rd_empty;
  logic [8:0] o_rd_words;
  logic [1:0] o_err;

  int checks   = 0;
  int failures = 0;

  fifo_ptr_mc dut (
    .clk          (clk),
    .rst          (rst),
    .i_wr_advance (i_wr_advance),
    .i_wr_ch      (i_wr_ch),
    .o_wr_addr    (o_wr_addr),
    .o_wr_full    (o_wr_full),
    .o_wr_afull   (o_wr_afull),
    .i_rd_advance (i_rd_advance),
    .i_rd_ch      (i_rd_ch),
    .o_rd_addr_nxt(o_rd_addr_nxt),
    .o_rd_empty   (o_rd_empty),
    .o_rd_words   (o_rd_words),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_wr_advance = 1'b0;
    i_rd_advance = 1'b0;
  endtask

  logic [1:0] exp_err;
  logic [7:0] wp;
  logic [7:0] rp;

  initial begin
    rst = 1'b1;
    i_wr_advance = 1'b0; i_wr_ch = 2'd0;
    i_rd_advance = 1'b0; i_rd_ch = 2'd0;
    exp_err = 2'b00;
    step(); step();
    rst = 1'b0;
    step();

    // post-reset state
    check_eq("rst_empty", o_rd_empty, 4'hF);
    check_eq("rst_full",  o_wr_full,  4'h0);
    check_eq("rst_afull", o_wr_afull, 4'h0);
    check_eq("rst_words", o_rd_words, 9'd0);
    check_eq("rst_err",   o_err,      2'b00);

    // fill ch1: afull after write 192, full after write 256
    i_wr_ch = 2'd1; i_rd_ch = 2'd1;
    for (int k = 0; k < 256; k++) begin
      i_wr_advance = 1'b1;
      #1;
      check_eq("fill_wr_addr", o_wr_addr, {2'd1, 8'(k)});
      step();
      if (k == 190) check_eq("afull_191", o_wr_afull[1], 1'b0);
      if (k == 191) check_eq("afull_192", o_wr_afull[1], 1'b1);
      if (k == 254) check_eq("full_255",  o_wr_full[1],  1'b0);
      if (k == 255) check_eq("full_256",  o_wr_full[1],  1'b1);
    end
    check_eq("fill_words", o_rd_words, 9'd256);
    check_eq("fill_empty", o_rd_empty, 4'b1101);
    // 257th write rejected
    #1;
    check_eq("ovf_wr_addr", o_wr_addr, {2'd1, 8'd0});
    step();
    idle();
    #1;
    check_eq("ovf_wr_addr_after", o_wr_addr, {2'd1, 8'd0});
    check_eq("ovf_words", o_rd_words, 9'd256);
    exp_err = ERR_EN ? 2'b01 : 2'b00;
    check_eq("ovf_err", o_err, exp_err);

    // ch2: preload wr_ptr=252, rd_ptr=248, count=4
    i_wr_ch = 2'd2; i_rd_ch = 2'd2;
    i_wr_advance = 1'b1;
    for (int k = 0; k < 4; k++) step();
    i_rd_advance = 1'b1;
    for (int k = 0; k < 248; k++) step();
    check_eq("pre_words", o_rd_words, 9'd4);
    wp = 8'd252; rp = 8'd248;
    for (int k = 0; k < 10; k++) begin
      #1;
      check_eq("wrap_wr_addr", o_wr_addr, {2'd2, wp});
      check_eq("wrap_rd_addr", o_rd_addr_nxt, {2'd2, 8'(rp + 8'd1)});
      step();
      check_eq("wrap_words", o_rd_words, 9'd4);
      wp = wp + 8'd1; rp = rp + 8'd1;
    end
    idle();
    #1;
    check_eq("wrap_wr_final", o_wr_addr, {2'd2, 8'd6});
    check_eq("wrap_rd_final", o_rd_addr_nxt, {2'd2, 8'd2});

    // ch0 empty: same-cycle write and read -> read rejected
    i_wr_ch = 2'd0; i_rd_ch = 2'd0;
    i_wr_advance = 1'b1; i_rd_advance = 1'b1;
    #1;
    check_eq("nft_rd_addr", o_rd_addr_nxt, {2'd0, 8'd0});
    step();
    idle();
    #1;
    check_eq("nft_words", o_rd_words, 9'd1);
    check_eq("nft_empty0", o_rd_empty[0], 1'b0);
    check_eq("nft_rd_addr_after", o_rd_addr_nxt, {2'd0, 8'd0});
    exp_err = ERR_EN ? 2'b11 : 2'b00;
    check_eq("nft_err", o_err, exp_err);

    // ch3 preload with 5 words
    i_wr_ch = 2'd3; i_wr_advance = 1'b1;
    for (int k = 0; k < 5; k++) step();
    // interleave: write ch0, read ch3
    i_wr_ch = 2'd0; i_rd_ch = 2'd3; i_rd_advance = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("il_wr_addr", o_wr_addr, {2'd0, 8'(k + 1)});
      check_eq("il_rd_addr", o_rd_addr_nxt, {2'd3, 8'(k + 1)});
      step();
      check_eq("il_words3", o_rd_words, 9'(4 - k));
    end
    idle();
    #1;
    check_eq("il_empty", o_rd_empty, 4'b1000);
    check_eq("il_full",  o_wr_full,  4'b0010);
    check_eq("il_afull", o_wr_afull, 4'b0010);
    i_rd_ch = 2'd0; #1; check_eq("il_words0", o_rd_words, 9'd6);
    i_rd_ch = 2'd1; #1; check_eq("il_words1", o_rd_words, 9'd256);
    i_rd_ch = 2'd2; #1; check_eq("il_words2", o_rd_words, 9'd4);

    // reset mid-operation with ch1 holding 50 words and a read in flight
    rst = 1'b1; step(); rst = 1'b0;
    i_wr_ch = 2'd1; i_wr_advance = 1'b1;
    for (int k = 0; k < 50; k++) step();
    i_wr_advance = 1'b0;
    i_rd_ch = 2'd1;
    #1;
    check_eq("pre_rst_words", o_rd_words, 9'd50);
    i_rd_advance = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    check_eq("mrst_empty", o_rd_empty, 4'hF);
    check_eq("mrst_full",  o_wr_full,  4'h0);
    check_eq("mrst_afull", o_wr_afull, 4'h0);
    check_eq("mrst_err",   o_err,      2'b00);
    check_eq("mrst_wr_addr", o_wr_addr, {2'd1, 8'd0});
    check_eq("mrst_rd_addr", o_rd_addr_nxt, {2'd1, 8'd0});
    for (int c = 0; c < 4; c++) begin
      i_rd_ch = 2'(c);
      #1;
      check_eq("mrst_words", o_rd_words, 9'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
